// File: rtl/approx_mult_pkg.sv
// Shared types and sizing helpers for the approximate shift-add multiplier sequencer.
package approx_mult_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MULT    = 2'd1,
        RECOVER = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    // Width needed to express a recovery depth of 0..2W inclusive.
    function automatic int rw_of(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/approx_recovery_mask.sv
// Recovery mask: sets every bit at or above position 2W-rec; rec=0 yields an empty mask.
module approx_recovery_mask
    import approx_mult_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int RW = rw_of(W)
) (
    input  logic [RW-1:0]  rec,
    output logic [2*W-1:0] mask
);

    logic [RW-1:0]  sh;
    logic [2*W-1:0] onehot;

    // With rec=0 the one-hot bit falls off the top, so onehot-1 is all ones and the mask is empty.
    always_comb begin
        sh     = RW'(2 * W) - rec;
        onehot = (2 * W)'(1) << sh;
        mask   = ~(onehot - (2 * W)'(1));
    end

endmodule

// File: rtl/approx_mult_sequencer.sv
// Shift-add multiplier sequencer on a carry-free adder with partial error recovery.
// Optional macro ERR_FLAG_EN adds the err_flag output reporting an inexact result.
module approx_mult_sequencer
    import approx_mult_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int RW = rw_of(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [RW-1:0]  rec_bits,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef ERR_FLAG_EN
    output logic           err_flag,
`endif
    output logic [2*W-1:0] p
);

    localparam int KW = (W > 1) ? $clog2(W) : 1;

    seq_state_t     state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [RW-1:0]  rec_q, rec_d, rec_clamped;
    logic [2*W-1:0] s_q, s_d, e_q, e_d, p_q, p_d;
    logic [KW-1:0]  k_q, k_d;
    logic [2*W-1:0] pp, mask;
`ifdef ERR_FLAG_EN
    logic           err_q, err_d;
`endif

    approx_recovery_mask #(.W(W), .RW(RW)) u_mask (
        .rec  (rec_q),
        .mask (mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rec_q   <= '0;
            s_q     <= '0;
            e_q     <= '0;
            k_q     <= '0;
            p_q     <= '0;
`ifdef ERR_FLAG_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rec_q   <= rec_d;
            s_q     <= s_d;
            e_q     <= e_d;
            k_q     <= k_d;
            p_q     <= p_d;
`ifdef ERR_FLAG_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rec_d       = rec_q;
        s_d         = s_q;
        e_d         = e_q;
        k_d         = k_q;
        p_d         = p_q;
`ifdef ERR_FLAG_EN
        err_d       = err_q;
`endif
        rec_clamped = (rec_bits > RW'(2 * W)) ? RW'(2 * W) : rec_bits;
        pp          = b_q[k_q] ? ({{W{1'b0}}, a_q} << k_q) : '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    rec_d   = rec_clamped;
                    s_d     = '0;
                    e_d     = '0;
                    k_d     = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                // Carries are generated from the pre-update sum so S+E stays exact.
                s_d = s_q ^ pp;
                e_d = e_q + ((s_q & pp) << 1);
                k_d = k_q + KW'(1);
                if (k_q == KW'(W - 1))
                    state_d = RECOVER;
            end
            RECOVER: begin
                p_d     = s_q + (e_q & mask);
`ifdef ERR_FLAG_EN
                err_d   = |(e_q & ~mask);
`endif
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        p         = p_q;
`ifdef ERR_FLAG_EN
        err_flag  = err_q;
`endif
    end

endmodule
